// File: rtl/udp_pkg.sv
// Shared constants and FSM encoding for the UDP frame packer.
package udp_pkg;

  localparam int HDR_LEN = 2;
  localparam int LEN_W   = 11;
  localparam int TMO_W   = 16;
  localparam int SEQ_W   = 16;
  localparam int TCNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_REQ,
    S_HDR,
    S_DATA,
    S_GAP
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on
// pop_data whenever empty is low.
module sync_fifo_fwft #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity, and a resettable array cannot map to block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/udp_frame_packer.sv
// Packs an image byte stream into sequence-numbered UDP payloads and drives the
// ethernet controller's request/ack/data interface.
module udp_frame_packer
  import udp_pkg::*;
#(
  parameter int PAYLOAD_LEN = 1024,
  parameter int FIFO_DEPTH  = 2048,
  parameter int ACK_TIMEOUT = 65535,
  parameter int GAP_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        udp_tx_ready,
  output logic        app_tx_data_request,
  output logic [15:0] udp_data_length,
  input  logic        app_tx_ack,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pkt_count,
  output logic [7:0]  timeout_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PAYLOAD_C = CW'(PAYLOAD_LEN);

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [7:0]        fifo_data;
  logic              push;
  logic              flush;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_launch;
  logic [LEN_W-1:0]  step;
  logic [TMO_W-1:0]  tmo;
  logic [SEQ_W-1:0]  seq;
  logic              launch;
  logic              ack_timeout;
  logic              data_done;
  logic              gap_done;
  logic              frame_end;

  assign in_ready = !fifo_full && !flush;
  assign push     = in_valid && in_ready;

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A flushing image sends whatever is left, capped at one full payload.
  assign launch      = (fifo_count >= PAYLOAD_C) || (flush && fifo_count != '0);
  assign len_launch  = (flush && fifo_count < PAYLOAD_C) ? LEN_W'(fifo_count)
                                                         : LEN_W'(PAYLOAD_LEN);
  assign ack_timeout = (tmo == TMO_W'(ACK_TIMEOUT - 1));
  assign data_done   = (step == len - 1'b1);
  assign gap_done    = (step == LEN_W'(GAP_CYCLES - 1));
  // Flush blocks pushes, so a count of one on the final pop means the image is done.
  assign frame_end   = flush && (fifo_count == CW'(1));
  assign busy        = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next          = state;
    fifo_pop            = 1'b0;
    app_tx_data_request = 1'b0;
    app_tx_data_valid   = 1'b0;
    app_tx_data         = '0;
    case (state)
      S_IDLE:     if (launch) state_next = S_WAIT_RDY;
      S_WAIT_RDY: if (udp_tx_ready) state_next = S_REQ;
      S_REQ: begin
        app_tx_data_request = 1'b1;
        if (app_tx_ack)       state_next = S_HDR;
        else if (ack_timeout) state_next = S_WAIT_RDY;
      end
      S_HDR: begin
        app_tx_data_valid = 1'b1;
        app_tx_data       = step[0] ? seq[7:0] : seq[15:8];
        if (step[0]) state_next = S_DATA;
      end
      S_DATA: begin
        app_tx_data_valid = 1'b1;
        app_tx_data       = fifo_data;
        fifo_pop          = 1'b1;
        if (data_done) state_next = S_GAP;
      end
      S_GAP:      if (gap_done) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush           <= 1'b0;
      len             <= '0;
      udp_data_length <= '0;
      step            <= '0;
      tmo             <= '0;
      seq             <= '0;
      pkt_count       <= '0;
      timeout_count   <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      step       <= (state_next != state) ? '0 : step + 1'b1;
      tmo        <= (state == S_REQ && state_next == S_REQ) ? tmo + 1'b1 : '0;

      if (push && in_last) flush <= 1'b1;

      if (state == S_IDLE && launch) begin
        len             <= len_launch;
        udp_data_length <= 16'(len_launch) + 16'(HDR_LEN);
      end

      if (state == S_REQ && !app_tx_ack && ack_timeout && timeout_count != 8'hFF) begin
        timeout_count <= timeout_count + 1'b1;
      end

      if (state == S_DATA && data_done) begin
        pkt_count <= pkt_count + 1'b1;
        if (frame_end) begin
          seq        <= '0;
          frame_done <= 1'b1;
          flush      <= 1'b0;
        end else begin
          seq <= seq + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_frame_packer.sv
// Directed bench for udp_frame_packer: an image table plus hand sequences for
// ready stall, ack timeout, FIFO backpressure and reset mid-packet.
module tb_udp_frame_packer;

  localparam int PL  = 512;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        udp_tx_ready;
  logic        app_tx_data_request;
  logic [15:0] udp_data_length;
  logic        app_tx_ack;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] pkt_count;
  logic [7:0]  timeout_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int pushed = 0;
  int fd_count = 0;
  int fd_exp = 0;
  int pkt_total = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int          nbytes;
    logic [7:0]  base;
    int          ack_delay;
    int          exp_pkts;
    logic [15:0] exp_last_len;
  } vec_t;

  vec_t vecs[5];

  udp_frame_packer #(
    .PAYLOAD_LEN (PL),
    .FIFO_DEPTH  (2048),
    .ACK_TIMEOUT (50),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_data_request (app_tx_data_request),
    .udp_data_length     (udp_data_length),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .busy                (busy),
    .frame_done          (frame_done),
    .pkt_count           (pkt_count),
    .timeout_count       (timeout_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_count++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; each byte is taken on the following posedge if in_ready.
  task automatic push_image(input int n, input logic [7:0] base);
    int i = 0;
    int stall = 0;
    while (i < n && stall < 5000) begin
      in_valid = 1'b1;
      in_data  = base + i[7:0];
      in_last  = (i == n - 1);
      if (in_ready) begin
        exp_q.push_back(in_data);
        i++;
        pushed++;
        stall = 0;
      end else begin
        stall++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("push_complete", i, n);
  endtask

  task automatic recv_pkt(input int ack_delay, input logic [15:0] exp_len, input logic [15:0] exp_seq);
    int n = 0;
    int errs = 0;
    logic [7:0] e;
    while (!app_tx_data_request && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", app_tx_data_request, 1'b1);
    if (!app_tx_data_request) return;
    check("udp_len", udp_data_length, exp_len);
    repeat (ack_delay) @(negedge clk);
    app_tx_ack = 1'b1;
    @(negedge clk);
    app_tx_ack = 1'b0;
    check("req_drop_after_ack", app_tx_data_request, 1'b0);
    check("hdr_hi", {app_tx_data_valid, app_tx_data}, {1'b1, exp_seq[15:8]});
    @(negedge clk);
    check("hdr_lo", {app_tx_data_valid, app_tx_data}, {1'b1, exp_seq[7:0]});
    for (int i = 0; i < int'(exp_len) - 2; i++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      if (!app_tx_data_valid || app_tx_data !== e || udp_data_length !== exp_len) errs++;
    end
    check("pkt_data_errors", errs, 0);
    @(negedge clk);
    check("valid_low_after_pkt", app_tx_data_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {app_tx_data_request, app_tx_data_valid, app_tx_data, udp_data_length,
                 busy, frame_done, pkt_count, timeout_count}, 64'd0);
    check({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int n;
    int bad;
    vecs[0] = '{nbytes: 1024, base: 8'h00, ack_delay: 3, exp_pkts: 2, exp_last_len: 16'd514};
    vecs[1] = '{nbytes: 700,  base: 8'h00, ack_delay: 3, exp_pkts: 2, exp_last_len: 16'd190};
    vecs[2] = '{nbytes: 512,  base: 8'h37, ack_delay: 0, exp_pkts: 1, exp_last_len: 16'd514};
    vecs[3] = '{nbytes: 1,    base: 8'hA5, ack_delay: 1, exp_pkts: 1, exp_last_len: 16'd3};
    vecs[4] = '{nbytes: 513,  base: 8'h11, ack_delay: 5, exp_pkts: 2, exp_last_len: 16'd3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    udp_tx_ready = 1'b1; app_tx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");

    // Image table: full packets carry 514, the last carries the remainder + 2.
    for (int v = 0; v < 5; v++) begin
      fork
        push_image(vecs[v].nbytes, vecs[v].base);
        for (int p = 0; p < vecs[v].exp_pkts; p++)
          recv_pkt(vecs[v].ack_delay,
                   (p == vecs[v].exp_pkts - 1) ? vecs[v].exp_last_len : 16'd514,
                   16'(p));
      join
      pkt_total += vecs[v].exp_pkts;
      fd_exp++;
      repeat (GAP + 2) @(negedge clk);
      check("tbl_pkt_count", pkt_count, pkt_total);
      check("tbl_frame_done_count", fd_count, fd_exp);
      check("tbl_busy_idle", busy, 1'b0);
      check("tbl_scoreboard_empty", exp_q.size(), 0);
    end

    // Ready held low with a full payload buffered.
    udp_tx_ready = 1'b0;
    push_image(512, 8'h5C);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (app_tx_data_request) bad++;
    end
    check("no_req_while_not_ready", bad, 0);
    udp_tx_ready = 1'b1;
    @(negedge clk);
    check("req_one_cycle_after_ready", app_tx_data_request, 1'b1);
    recv_pkt(3, 16'd514, 16'd0);
    pkt_total++; fd_exp++;

    // Ack withheld on the first request.
    push_image(100, 8'hC3);
    n = 0;
    while (!app_tx_data_request && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (app_tx_data_request && n < 200) begin @(negedge clk); n++; end
    check("req_high_cycles_before_timeout", n, 50);
    check("timeout_count_one", timeout_count, 8'd1);
    recv_pkt(2, 16'd102, 16'd0);
    pkt_total++; fd_exp++;
    repeat (GAP + 2) @(negedge clk);
    check("pkt_count_after_retry", pkt_count, pkt_total);

    // Backpressure: fill the FIFO with the UDP side stalled.
    udp_tx_ready = 1'b0;
    pushed = 0;
    fork
      push_image(2560, 8'h80);
      begin
        n = 0;
        while (in_ready && n < 3000) begin @(negedge clk); n++; end
        check("in_ready_low_when_full", in_ready, 1'b0);
        check("bytes_accepted_at_full", pushed, 2048);
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (in_ready) bad++;
        end
        check("in_ready_stays_low", bad, 0);
        udp_tx_ready = 1'b1;
        for (int p = 0; p < 5; p++) recv_pkt(3, 16'd514, 16'(p));
      end
    join
    pkt_total += 5; fd_exp++;
    repeat (GAP + 2) @(negedge clk);
    check("bp_pkt_count", pkt_count, pkt_total);
    check("bp_frame_done_count", fd_count, fd_exp);
    check("bp_scoreboard_empty", exp_q.size(), 0);

    // Reset asserted in the middle of DATA.
    push_image(512, 8'h90);
    n = 0;
    while (!app_tx_data_request && n < 200) begin @(negedge clk); n++; end
    app_tx_ack = 1'b1;
    @(negedge clk);
    app_tx_ack = 1'b0;
    repeat (20) @(negedge clk);
    check("valid_before_reset", app_tx_data_valid, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset_mid_data");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fd_count = 0;
    @(negedge clk);
    push_image(512, 8'h2B);
    recv_pkt(3, 16'd514, 16'd0);
    repeat (GAP + 2) @(negedge clk);
    check("pkt_count_after_reset", pkt_count, 16'd1);
    check("frame_done_after_reset", fd_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
